// File: rtl/rr_mux_reg.sv
// ---------------------------------------------------------------------------
// rr_mux_reg
//
// N-channel, WIDTH-bit merge point with one registered output stage. Each
// producer offers a word with in_valid and sees it taken on in_ready. An
// internal arbiter picks one channel per cycle, either round-robin (MODE 0)
// or lowest-index-wins (MODE 1). The chosen word is captured into a single
// output register and presented to the consumer with out_valid/out_ready.
// The output register is held stable while the consumer stalls.
//
// Parameters
//   WIDTH    : data width per channel (>= 1)
//   CHANNELS : number of input channels (>= 2)
//   MODE     : 0 = round-robin, 1 = fixed priority (lowest index wins)
//   CW       : derived channel-index width, max(1, clog2(CHANNELS))
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_data   in   CHANNELS*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid  in   CHANNELS, channel i offers a word
//   in_ready  out  CHANNELS, channel i's word taken this cycle (one-hot or 0)
//   out_data  out  WIDTH, registered selected word
//   out_chan  out  CW, channel that supplied out_data
//   out_valid out  1, output register holds a word
//   out_ready in   1, consumer accepts out_data this cycle
// ---------------------------------------------------------------------------
module rr_mux_reg #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = 0,
  localparam int CW       = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Highest legal channel index, used for the explicit pointer wrap.
  localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] out_data_d;
  logic [CW-1:0]    out_chan_q;
  logic [CW-1:0]    out_chan_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [CW-1:0]    ptr_q;
  logic [CW-1:0]    ptr_d;

  // -------------------------------------------------------------------------
  // Combinational arbitration signals
  // -------------------------------------------------------------------------
  logic             load_s;      // output register can take a word
  logic             any_valid_s; // at least one channel is offering
  logic [CW-1:0]    grant_s;     // winning channel this cycle
  logic             xfer_s;      // a word moves into the register at the edge
  logic [WIDTH-1:0] sel_data_s;  // word of the winning channel

  // The register is free when empty or when it is being drained this cycle,
  // which is what gives back-to-back throughput without a bubble.
  assign load_s = ~out_valid_q | out_ready;
  assign xfer_s = load_s & any_valid_s;

  // Arbiter: search from ptr (round-robin) or from 0 (fixed priority) and
  // take the first offering channel. The index is wrapped by subtraction so
  // that non-power-of-two channel counts never index past CHANNELS-1.
  always_comb begin
    int          idx;
    logic [CW-1:0] idx_cw;
    logic        found;
    any_valid_s = 1'b0;
    grant_s     = '0;
    found       = 1'b0;
    idx         = 0;
    idx_cw      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (MODE == 0) begin
        idx = int'(ptr_q) + k;
      end else begin
        idx = k;
      end
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end else begin
        idx = idx;
      end
      idx_cw = CW'(idx);
      if (!found && in_valid[idx_cw]) begin
        found   = 1'b1;
        grant_s = idx_cw;
      end else begin
        found   = found;
      end
    end
    any_valid_s = found;
  end

  // Data select for the granted channel; constant part-selects keep this a
  // plain mux with no variable-width arithmetic on the index.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(grant_s) == i) begin
        sel_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Handshake back to producers: only the granted channel sees ready, and
  // only while the register can load. Gated by rst_n so producers never see
  // an acceptance while the block is held in reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if ((int'(grant_s) == i) && xfer_s && rst_n) begin
        in_ready[i] = 1'b1;
      end else begin
        in_ready[i] = 1'b0;
      end
    end
  end

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer_s) begin
      out_data_d  = sel_data_s;
      out_chan_d  = grant_s;
      out_valid_d = 1'b1;
      // Pointer moves past the winner only on an actual transfer, so a
      // stalled grant never costs a channel its turn.
      if (MODE == 0) begin
        if (grant_s == LAST_CHAN) begin
          ptr_d = '0;
        end else begin
          ptr_d = grant_s + CW'(1);
        end
      end else begin
        ptr_d = ptr_q;
      end
    end else if (out_valid_q && out_ready) begin
      // Drained with nothing to replace it: data and channel hold.
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous clear; a held word is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_reg
//
// Exercises three configurations of rr_mux_reg side by side:
//   u_a : MODE 0, CHANNELS 4, WIDTH 8  (reset, fairness, wrap, back-pressure)
//   u_b : MODE 1, CHANNELS 4, WIDTH 8  (fixed priority)
//   u_c : MODE 0, CHANNELS 3, WIDTH 16 (non-power-of-two wrap)
// Expected {chan, data} words are queued when stimulus is driven and
// compared when the consumer side takes a word.
// ---------------------------------------------------------------------------
module tb_rr_mux_reg;

  logic clk;
  logic rst_n;

  // u_a
  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid;
  logic [3:0]  a_in_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_chan;
  logic        a_out_valid;
  logic        a_out_ready;
  // u_b
  logic [31:0] b_in_data;
  logic [3:0]  b_in_valid;
  logic [3:0]  b_in_ready;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_chan;
  logic        b_out_valid;
  logic        b_out_ready;
  // u_c
  logic [47:0] c_in_data;
  logic [2:0]  c_in_valid;
  logic [2:0]  c_in_ready;
  logic [15:0] c_out_data;
  logic [1:0]  c_out_chan;
  logic        c_out_valid;
  logic        c_out_ready;

  int errors = 0;
  int checks = 0;

  // Scoreboards: {chan[7:0], data[15:0]}
  logic [23:0] qa[$];
  logic [23:0] qb[$];
  logic [23:0] qc[$];

  rr_mux_reg #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_chan(a_out_chan),
    .out_valid(a_out_valid), .out_ready(a_out_ready));

  rr_mux_reg #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_chan(b_out_chan),
    .out_valid(b_out_valid), .out_ready(b_out_ready));

  rr_mux_reg #(.WIDTH(16), .CHANNELS(3), .MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_chan(c_out_chan),
    .out_valid(c_out_valid), .out_ready(c_out_ready));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer-side monitors: a word shown with out_ready high at the falling
  // edge is taken on the next rising edge, so compare it here.
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_word", {24'h0, a_out_data}, 32'hFFFF_FFFF);
      end else begin
        e = qa.pop_front();
        chk("a_chan", {30'h0, a_out_chan}, {24'h0, e[23:16]});
        chk("a_data", {24'h0, a_out_data}, {24'h0, e[7:0]});
      end
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_word", {24'h0, b_out_data}, 32'hFFFF_FFFF);
      end else begin
        e = qb.pop_front();
        chk("b_chan", {30'h0, b_out_chan}, {24'h0, e[23:16]});
        chk("b_data", {24'h0, b_out_data}, {24'h0, e[7:0]});
      end
    end
    if (rst_n && c_out_valid && c_out_ready) begin
      if (qc.size() == 0) begin
        chk("c_unexpected_word", {16'h0, c_out_data}, 32'hFFFF_FFFF);
      end else begin
        e = qc.pop_front();
        chk("c_chan", {30'h0, c_out_chan}, {24'h0, e[23:16]});
        chk("c_data", {16'h0, c_out_data}, {16'h0, e[15:0]});
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    a_in_data   = 32'h0;  a_in_valid = 4'hF; a_out_ready = 1'b0;
    b_in_data   = 32'h0;  b_in_valid = 4'h0; b_out_ready = 1'b1;
    c_in_data   = 48'h0;  c_in_valid = 3'h0; c_out_ready = 1'b1;

    // ---------------- reset state ----------------
    #2;
    chk("rst_a_valid", {31'h0, a_out_valid}, 32'h0);
    chk("rst_a_data", {24'h0, a_out_data}, 32'h0);
    chk("rst_a_chan", {30'h0, a_out_chan}, 32'h0);
    chk("rst_a_ready", {28'h0, a_in_ready}, 32'h0);
    a_in_valid = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

    // ---------------- round-robin fairness ----------------
    a_in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    a_out_ready = 1'b1;
    a_in_valid  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", {28'h0, a_in_ready}, 32'(4'b0001 << (k % 4)));
      qa.push_back({8'(k % 4), 8'h0, 8'(8'h10 + (k % 4))});
      tick();
      chk("rr_out_valid", {31'h0, a_out_valid}, 32'h1);
    end
    a_in_valid = 4'h0;
    tick();
    chk("rr_drained", {31'h0, a_out_valid}, 32'h0);
    chk("rr_ptr", {30'h0, u_a.ptr_q}, 32'h1);

    // ---------------- skip and wrap ----------------
    a_in_valid = 4'b0100;
    #1;
    chk("sw_ready_c2", {28'h0, a_in_ready}, 32'h4);
    qa.push_back({8'd2, 8'h0, 8'h12});
    tick();
    a_in_valid = 4'b0101;
    #1;
    chk("sw_ptr3", {30'h0, u_a.ptr_q}, 32'h3);
    chk("sw_ready_wrap", {28'h0, a_in_ready}, 32'h1);
    qa.push_back({8'd0, 8'h0, 8'h10});
    tick();
    chk("sw_ptr1", {30'h0, u_a.ptr_q}, 32'h1);
    #1;
    chk("sw_ready_skip", {28'h0, a_in_ready}, 32'h4);
    qa.push_back({8'd2, 8'h0, 8'h12});
    tick();
    a_in_valid = 4'h0;
    tick();

    // ---------------- back-pressure ----------------
    a_out_ready = 1'b0;
    a_in_valid  = 4'b1000;
    #1;
    chk("bp_empty_accept", {28'h0, a_in_ready}, 32'h8);
    qa.push_back({8'd3, 8'h0, 8'h13});
    tick();
    a_in_data[15:8] = 8'hA5;
    a_in_valid      = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", {28'h0, a_in_ready}, 32'h0);
      chk("bp_hold_data", {24'h0, a_out_data}, 32'h13);
      chk("bp_hold_chan", {30'h0, a_out_chan}, 32'h3);
      chk("bp_hold_valid", {31'h0, a_out_valid}, 32'h1);
      chk("bp_hold_ptr", {30'h0, u_a.ptr_q}, 32'h0);
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {28'h0, a_in_ready}, 32'h2);
    qa.push_back({8'd1, 8'h0, 8'hA5});
    tick();
    a_in_valid = 4'h0;
    chk("bp_loaded_data", {24'h0, a_out_data}, 32'hA5);
    chk("bp_ptr", {30'h0, u_a.ptr_q}, 32'h2);
    tick();

    // ---------------- reset mid-stall ----------------
    a_out_ready = 1'b0;
    a_in_data[7:0] = 8'h77;
    a_in_valid = 4'b0001;
    tick();
    #1;
    chk("ms_full", {31'h0, a_out_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ms_valid", {31'h0, a_out_valid}, 32'h0);
    chk("ms_data", {24'h0, a_out_data}, 32'h0);
    chk("ms_chan", {30'h0, a_out_chan}, 32'h0);
    chk("ms_ptr", {30'h0, u_a.ptr_q}, 32'h0);
    chk("ms_ready", {28'h0, a_in_ready}, 32'h0);
    rst_n      = 1'b1;
    a_in_valid = 4'h0;
    tick();
    chk("ms_no_replay", {31'h0, a_out_valid}, 32'h0);
    a_out_ready = 1'b1;
    tick();
    chk("ms_still_empty", {31'h0, a_out_valid}, 32'h0);

    // ---------------- fixed priority ----------------
    b_in_data  = {8'h23, 8'h22, 8'h21, 8'h20};
    b_in_valid = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fp_ready", {28'h0, b_in_ready}, 32'h2);
      qb.push_back({8'd1, 8'h0, 8'h21});
      tick();
      chk("fp_chan", {30'h0, b_out_chan}, 32'h1);
    end
    b_in_valid = 4'h0;
    tick();
    chk("fp_drained", {31'h0, b_out_valid}, 32'h0);

    // ---------------- non-power-of-two ----------------
    c_in_data  = {16'hC002, 16'hC001, 16'hC000};
    c_in_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("np2_ptr", {30'h0, u_c.ptr_q}, 32'(k % 3));
      chk("np2_ready", {29'h0, c_in_ready}, 32'(3'b001 << (k % 3)));
      qc.push_back({8'(k % 3), 16'(16'hC000 + (k % 3))});
      tick();
    end
    c_in_valid = 3'h0;
    #1;
    chk("np2_last_valid", {31'h0, c_out_valid}, 32'h1);
    chk("np2_ptr_wrap", {30'h0, u_c.ptr_q}, 32'h1);
    tick();
    chk("np2_drained", {31'h0, c_out_valid}, 32'h0);

    tick();
    chk("qa_empty", 32'(qa.size()), 32'h0);
    chk("qb_empty", 32'(qb.size()), 32'h0);
    chk("qc_empty", 32'(qc.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
